// File: rtl/mul_controller.sv
// Sequencer for a shift-free add-and-count multiplier datapath: loads A, loads/clears B and P, adds until B==0.
// Moore strobes are registered from the next-state decode; ldp/decb are a Mealy decode on eqz in ADD.
module mul_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ack,
    input  logic        abort,
    input  logic        eqz,
    output logic        lda,
    output logic        ldb,
    output logic        clrp,
    output logic        ldp,
    output logic        decb,
    output logic        bus_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] iter_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_ADD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_lda;
    logic        r_ldb;
    logic        r_bus_sel;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_iter;
    logic        w_add_step;

    assign w_add_step = (r_state == S_ADD) && !eqz;

    // Abort wins over eqz in ADD so a cancelled run never reaches DONE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_LDA : S_IDLE;
            S_LDA:   w_next = abort ? S_IDLE : S_LDB;
            S_LDB:   w_next = abort ? S_IDLE : S_ADD;
            S_ADD:   w_next = abort ? S_IDLE : (eqz ? S_DONE : S_ADD);
            S_DONE:  w_next = ack ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lda     <= 1'b0;
            r_ldb     <= 1'b0;
            r_bus_sel <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_iter    <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_lda     <= (w_next == S_LDA);
            r_ldb     <= (w_next == S_LDB);
            r_bus_sel <= (w_next == S_LDB);
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_DONE);
            // The add in an aborted ADD cycle still happens, so it is still counted.
            if (r_state == S_LDA)
                r_iter <= 16'd0;
            else if (w_add_step && (r_iter != 16'hFFFF))
                r_iter <= r_iter + 16'd1;
        end
    end

    assign lda      = r_lda;
    assign ldb      = r_ldb;
    assign clrp     = r_ldb;
    assign bus_sel  = r_bus_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ldp      = w_add_step;
    assign decb     = w_add_step;
    assign iter_cnt = r_iter;
    assign state    = r_state;

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural multiplier datapath and a queue-based scoreboard.
module tb_mul_controller;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        abort = 1'b0;
    logic        eqz;
    logic        lda, ldb, clrp, ldp, decb, bus_sel, busy, done;
    logic [15:0] iter_cnt;
    logic [2:0]  state;

    // Datapath model
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic [7:0]  a_reg = 8'd0;
    logic [7:0]  b_cnt = 8'd0;
    logic [15:0] p_reg = 16'd0;
    logic [7:0]  bus;
    logic        eqz_man_en = 1'b0;
    logic        eqz_man = 1'b0;

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  strb;
        logic [15:0] it;
    } exp_t;

    typedef struct {
        logic [15:0] prod;
        logic [15:0] it;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    mul_controller dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ack      (ack),
        .abort    (abort),
        .eqz      (eqz),
        .lda      (lda),
        .ldb      (ldb),
        .clrp     (clrp),
        .ldp      (ldp),
        .decb     (decb),
        .bus_sel  (bus_sel),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt),
        .state    (state)
    );

    assign bus = bus_sel ? op_b : op_a;
    assign eqz = eqz_man_en ? eqz_man : (b_cnt == 8'd0);

    always @(posedge clk) begin
        if (lda) a_reg <= bus;
        if (ldb) b_cnt <= bus;
        else if (decb) b_cnt <= b_cnt - 8'd1;
        if (clrp) p_reg <= 16'd0;
        else if (ldp) p_reg <= p_reg + {8'd0, a_reg};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Strobe vector {lda,ldb,clrp,ldp,decb,bus_sel,busy,done} required in a given state.
    function automatic logic [7:0] strobes_for(input logic [2:0] s, input logic l);
        case (s)
            S_LDA:   return 8'b1000_0010;
            S_LDB:   return 8'b0110_0110;
            S_ADD:   return {3'b000, l, l, 1'b0, 1'b1, 1'b0};
            S_DONE:  return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    // Drive inputs for the current cycle and record what the DUT must show in it.
    task automatic step(input logic st, input logic ak, input logic ab, input logic rs,
                        input logic [2:0] es, input logic el, input logic [15:0] ei);
        exp_t e;
        #1;
        start = st;
        ack   = ak;
        abort = ab;
        rst   = rs;
        e.st   = es;
        e.strb = strobes_for(es, el);
        e.it   = ei;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic expect_result(input logic [15:0] prod, input logic [15:0] it);
        res_t r;
        r.prod = prod;
        r.it   = it;
        res_q.push_back(r);
    endtask

    // Monitor: per-cycle trace plus a result check on each rising edge of done.
    always @(negedge clk) begin
        exp_t e;
        res_t r;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", {29'd0, state}, {29'd0, e.st});
            check("strobes", {24'd0, lda, ldb, clrp, ldp, decb, bus_sel, busy, done}, {24'd0, e.strb});
            check("iter_cnt", {16'd0, iter_cnt}, {16'd0, e.it});
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (res_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                r = res_q.pop_front();
                check("product", {16'd0, p_reg}, {16'd0, r.prod});
                check("result_iter", {16'd0, iter_cnt}, {16'd0, r.it});
            end
        end
        prev_done = done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal: A=5, B=3, ack two cycles after done rises; ack also raised in IDLE first.
        op_a = 8'd5; op_b = 8'd3;
        step(0, 1, 0, 0, S_IDLE, 0, 0);
        expect_result(16'd15, 16'd3);
        step(1, 0, 0, 0, S_IDLE, 0, 0);
        step(0, 0, 0, 0, S_LDA,  0, 0);
        step(0, 0, 0, 0, S_LDB,  0, 0);
        step(0, 0, 0, 0, S_ADD,  1, 0);
        step(0, 0, 0, 0, S_ADD,  1, 1);
        step(0, 0, 0, 0, S_ADD,  1, 2);
        step(0, 0, 0, 0, S_ADD,  0, 3);
        step(0, 0, 0, 0, S_DONE, 0, 3);
        step(0, 0, 0, 0, S_DONE, 0, 3);
        step(0, 1, 0, 0, S_DONE, 0, 3);
        step(0, 0, 0, 0, S_IDLE, 0, 3);

        // Zero operand: A=7, B=0.
        op_a = 8'd7; op_b = 8'd0;
        expect_result(16'd0, 16'd0);
        step(1, 0, 0, 0, S_IDLE, 0, 3);
        step(0, 0, 0, 0, S_LDA,  0, 3);
        step(0, 0, 0, 0, S_LDB,  0, 0);
        step(0, 0, 0, 0, S_ADD,  0, 0);
        step(0, 1, 0, 0, S_DONE, 0, 0);
        step(0, 0, 0, 0, S_IDLE, 0, 0);

        // Abort on the 4th ADD cycle of A=4, B=10; abort in IDLE is harmless.
        op_a = 8'd4; op_b = 8'd10;
        step(1, 0, 1, 0, S_IDLE, 0, 0);
        step(0, 0, 0, 0, S_LDA,  0, 0);
        step(0, 0, 0, 0, S_LDB,  0, 0);
        step(0, 0, 0, 0, S_ADD,  1, 0);
        step(0, 0, 0, 0, S_ADD,  1, 1);
        step(0, 0, 0, 0, S_ADD,  1, 2);
        step(0, 0, 1, 0, S_ADD,  1, 3);
        step(0, 0, 0, 0, S_IDLE, 0, 4);
        step(0, 0, 0, 0, S_IDLE, 0, 4);

        // Follow-up A=2, B=2; abort while in DONE is ignored.
        op_a = 8'd2; op_b = 8'd2;
        expect_result(16'd4, 16'd2);
        step(1, 0, 0, 0, S_IDLE, 0, 4);
        step(0, 0, 0, 0, S_LDA,  0, 4);
        step(0, 0, 0, 0, S_LDB,  0, 0);
        step(0, 0, 0, 0, S_ADD,  1, 0);
        step(0, 0, 0, 0, S_ADD,  1, 1);
        step(0, 0, 0, 0, S_ADD,  0, 2);
        step(0, 0, 1, 0, S_DONE, 0, 2);
        step(0, 1, 0, 0, S_DONE, 0, 2);
        step(0, 0, 0, 0, S_IDLE, 0, 2);

        // start held throughout, ack while busy ignored, start+ack in DONE returns to IDLE.
        op_a = 8'd3; op_b = 8'd1;
        expect_result(16'd3, 16'd1);
        step(1, 0, 0, 0, S_IDLE, 0, 2);
        step(1, 1, 0, 0, S_LDA,  0, 2);
        step(1, 1, 0, 0, S_LDB,  0, 0);
        step(1, 1, 0, 0, S_ADD,  1, 0);
        step(1, 1, 0, 0, S_ADD,  0, 1);
        step(1, 0, 0, 0, S_DONE, 0, 1);
        step(1, 1, 0, 0, S_DONE, 0, 1);
        step(0, 0, 0, 0, S_IDLE, 0, 1);
        step(0, 0, 0, 0, S_IDLE, 0, 1);

        // Reset on the 2nd ADD cycle of A=3, B=6.
        op_a = 8'd3; op_b = 8'd6;
        step(1, 0, 0, 0, S_IDLE, 0, 1);
        step(0, 0, 0, 0, S_LDA,  0, 1);
        step(0, 0, 0, 0, S_LDB,  0, 0);
        step(0, 0, 0, 0, S_ADD,  1, 0);
        step(0, 0, 0, 1, S_ADD,  1, 1);
        step(0, 0, 0, 0, S_IDLE, 0, 0);

        // eqz wiggling in IDLE must not disturb any output.
        eqz_man_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eqz_man = i[0];
            step(0, 0, 0, 0, S_IDLE, 0, 0);
        end
        eqz_man_en = 1'b0;

        repeat (2) @(posedge clk);
        check("trace_drained", exp_q.size(), 32'd0);
        check("results_drained", res_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_controller.md
MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001 The block SHALL have exactly one clock, `clk`; reset is synchronous and active-high, named `rst`.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a multiply; sampled in IDLE only
- ack  input  1  consumer acknowledges result; sampled in DONE only
- abort  input  1  cancel an in-progress operation
- eqz  input  1  datapath flag: B counter equals zero
- lda  output  1  load operand A register from bus
- ldb  output  1  load B counter from bus
- clrp  output  1  clear product register
- ldp  output  1  load product register with adder result
- decb  output  1  decrement B counter
- bus_sel  output  1  bus source mux select: 0 = operand A, 1 = operand B
- busy  output  1  high in every state except IDLE
- done  output  1  result valid in product register
- iter_cnt  output  16  number of add iterations performed in the current or last operation
- state  output  3  current FSM state code, for debug

Function
REQ-003 The FSM SHALL have these states and codes: IDLE=0, LDA=1, LDB=2, ADD=3, DONE=4.
- Codes 5-7 SHALL go to IDLE on the next edge, with all strobes 0.
REQ-004 Transitions SHALL be as follows:
- IDLE->LDA when start=1.
- LDA->LDB unconditionally.
- LDB->ADD unconditionally.
- ADD->DONE when eqz=1; otherwise stay in ADD.
- DONE->IDLE when ack=1; otherwise stay in DONE.
REQ-005 In LDA the block SHALL drive lda=1, bus_sel=0; all other strobes 0.
REQ-006 In LDB the block SHALL drive ldb=1, clrp=1, bus_sel=1; all other strobes 0.
REQ-007 In ADD, ldp and decb SHALL both equal !eqz; this is a Mealy decode on eqz.
- No other strobes are asserted in ADD.
- bus_sel is 0 in all states other than LDB.
REQ-008 lda, ldb, clrp, bus_sel, busy, done and state SHALL be pure decodes of the state register (Moore).
REQ-009 done SHALL be 1 only in DONE, and SHALL stay high until the cycle in which ack=1.
REQ-010 iter_cnt handling:
- Cleared to 0 in LDA.
- Incremented by 1 on each ADD cycle with ldp=1, saturating at 0xFFFF.
- Held in all other states.
REQ-011 For a B operand value n, the state sequence SHALL be:
- LDA, then LDB, then n ADD cycles with strobes, then one ADD cycle with eqz=1, then DONE.
- Total: n+3 cycles from the first LDA cycle to the first DONE cycle.
REQ-012 When n=0, the block SHALL go LDB->ADD->DONE with ldp never asserted, and iter_cnt shall be 0.
REQ-013 start SHALL be ignored in every state other than IDLE, and ack SHALL be ignored in every state other than DONE.
REQ-014 If ack=1 and start=1 in the same DONE cycle, the block SHALL go to IDLE; start is not accepted that cycle.
REQ-015 If abort=1 in LDA, LDB or ADD, the block SHALL go to IDLE on the next edge.
- All strobes remain as decoded in the abort cycle.
- iter_cnt holds its value.
REQ-016 abort SHALL have no effect in IDLE or DONE.
REQ-017 rst SHALL take priority over abort, start and ack.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL load state=IDLE and iter_cnt=0.
- The resulting outputs are lda=ldb=clrp=ldp=decb=bus_sel=busy=done=0.
REQ-019 rst asserted mid-operation (any state) SHALL return the block to IDLE on that edge, discarding the operation.
REQ-020 No output SHALL be X after the first reset edge.

Verification
REQ-021 Nominal: with the datapath attached, A=5, B=3, start pulse, then ack two cycles after done.
- Required: states 1,2,3,3,3,3,4.
- Required: ldp/decb high 3 cycles.
- Required: product register = 15.
- Required: iter_cnt = 3.
- Required: done held until ack.
REQ-022 Zero operand: A=7, B=0.
- Required: LDA, LDB, one ADD cycle, then DONE.
- Required: ldp never asserted, product = 0, iter_cnt = 0.
REQ-023 Abort: A=4, B=10, abort=1 on the 4th ADD cycle.
- Required: IDLE next edge.
- Required: iter_cnt = 4.
- Required: done never asserted.
- Required: a later start with A=2, B=2 yields product = 4.
REQ-024 Handshake edges:
- start held high through an entire operation: exactly one operation runs.
- start and ack together in DONE: goes to IDLE, not LDA.
- ack asserted while busy and not in DONE: ignored.
REQ-025 Reset mid-run: rst=1 on the 2nd ADD cycle of A=3, B=6.
- Required: next cycle state=0, all outputs 0, iter_cnt = 0.
- Required: eqz toggled while in IDLE does not change outputs.
